knn_nat_initiator: RTL and testbench

- Native-interface bus master that drives the KNN peripheral from the CPU side of the protocol.
- Walks a KNN job autonomously:
  - soft-resets the peripheral;
  - writes the test point;
  - fetches training points from memory and streams them in;
  - polls DONE;
  - reads back the K nearest results.
- Frees the CPU from per-point register writes. Sits between a control register bank and the shared native interconnect.

---
 rtl/knn_nat_initiator.sv | 190 +++++++++++++++++++
 tb/tb_knn_nat_initiator.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_nat_initiator.sv
// Native-bus master that runs a complete KNN peripheral job: soft reset, test point, training stream, DONE poll, result readback.
// Optional KNN_TIMEOUT_EN adds a TIMEOUT_W watchdog on polling and on stalled transactions.
module knn_nat_initiator #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int K         = 10,
    parameter int TIMEOUT_W = 20,
    localparam int IDX_W    = (K > 1) ? $clog2(K) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   test_point,
    input  logic [ADDR_W-1:0]   train_base,
    input  logic [CNT_W-1:0]    train_cnt,
    input  logic [ADDR_W-1:0]   knn_base,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                res_valid,
    output logic [IDX_W-1:0]    res_idx,
    output logic [DATA_W-1:0]   res_data,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);
    localparam logic [ADDR_W-1:0] OFF_RESET = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_DATA1 = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] OFF_DATA2 = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] OFF_SEL   = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] OFF_DONE  = ADDR_W'(16);
    localparam logic [ADDR_W-1:0] OFF_DOUT  = ADDR_W'(20);

    typedef enum logic [3:0] {IDLE, RST1, RST0, WTEST, RDTR, WTR, POLL, SEL, RDOUT, FIN} state_t;
    state_t state;

    logic [DATA_W-1:0] tp;
    logic [ADDR_W-1:0] tbase;
    logic [ADDR_W-1:0] kbase;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  i;
    logic [IDX_W-1:0]  j;
    logic [DATA_W-1:0] rbuf;

    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_write;

    // Request contents for the state's single transaction.
    always_comb begin
        req_addr  = kbase;
        req_wdata = '0;
        req_write = 1'b1;
        case (state)
            RST1:  begin req_addr = kbase + OFF_RESET; req_wdata = DATA_W'(1); end
            RST0:  req_addr = kbase + OFF_RESET;
            WTEST: begin req_addr = kbase + OFF_DATA1; req_wdata = tp; end
            RDTR:  begin req_addr = tbase + (ADDR_W'(i) << 2); req_write = 1'b0; end
            WTR:   begin req_addr = kbase + OFF_DATA2; req_wdata = rbuf; end
            POLL:  begin req_addr = kbase + OFF_DONE; req_write = 1'b0; end
            SEL:   begin req_addr = kbase + OFF_SEL; req_wdata = DATA_W'(j); end
            RDOUT: begin req_addr = kbase + OFF_DOUT; req_write = 1'b0; end
            default: ;
        endcase
    end

`ifdef KNN_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo;
    logic                 expired;
    logic                 err_q;
    assign expired = &tmo;
    assign error   = err_q;

    // Counts POLL residency as a whole, otherwise the age of the outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo <= '0;
        else if (state == WTR && m_valid && m_ready)
            tmo <= '0;
        else if (state == POLL || m_valid) begin
            if (!expired)
                tmo <= tmo + TIMEOUT_W'(1);
        end else
            tmo <= '0;
    end
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
            m_valid   <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            tp        <= '0;
            tbase     <= '0;
            kbase     <= '0;
            cnt       <= '0;
            i         <= '0;
            j         <= '0;
            rbuf      <= '0;
`ifdef KNN_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    tp    <= test_point;
                    tbase <= train_base;
                    kbase <= knn_base;
                    cnt   <= train_cnt;
`ifdef KNN_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                    if (train_cnt == '0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        busy  <= 1'b1;
                        state <= RST1;
                    end
                end
                FIN: state <= IDLE;
                default: begin
`ifdef KNN_TIMEOUT_EN
                    if (expired && ((state == POLL && !m_valid) ||
                                    (state != POLL && m_valid && !m_ready))) begin
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err_q   <= 1'b1;
                        state   <= FIN;
                    end else
`endif
                    if (!m_valid) begin
                        m_valid   <= 1'b1;
                        m_address <= req_addr;
                        m_wdata   <= req_wdata;
                        m_wstrb   <= req_write ? '1 : '0;
                    end else if (m_ready) begin
                        // Completion cycle: drop valid so the registered-ready slave sees a gap.
                        m_valid <= 1'b0;
                        case (state)
                            RST1:  state <= RST0;
                            RST0:  state <= WTEST;
                            WTEST: begin i <= '0; state <= RDTR; end
                            RDTR:  begin rbuf <= m_rdata; state <= WTR; end
                            WTR: begin
                                i <= i + CNT_W'(1);
                                state <= (i + CNT_W'(1) == cnt) ? POLL : RDTR;
                            end
                            POLL: if (m_rdata[0]) begin
                                j     <= '0;
                                state <= SEL;
                            end
                            SEL:   state <= RDOUT;
                            RDOUT: begin
                                res_valid <= 1'b1;
                                res_idx   <= j;
                                res_data  <= m_rdata;
                                if (j == IDX_W'(K - 1)) begin
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= FIN;
                                end else begin
                                    j     <= j + IDX_W'(1);
                                    state <= SEL;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_knn_nat_initiator.sv
// Bench for knn_nat_initiator: memory/peripheral slave model, bus monitor, and job-level reference traces.
module tb_knn_nat_initiator;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int KK = 2;
    localparam int IW = 1;
`ifdef KNN_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 20;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [DW-1:0] test_point = '0;
    logic [AW-1:0] train_base = '0;
    logic [CW-1:0] train_cnt = '0;
    logic [AW-1:0] knn_base = '0;
    logic busy, done, error, res_valid;
    logic [IW-1:0] res_idx;
    logic [DW-1:0] res_data;
    logic m_valid;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic [DW-1:0] m_rdata;
    logic m_ready;

    int vectors = 0;
    int miscompares = 0;

    knn_nat_initiator #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .K(KK), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .test_point(test_point), .train_base(train_base),
        .train_cnt(train_cnt), .knn_base(knn_base), .busy(busy), .done(done), .error(error),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data), .m_valid(m_valid),
        .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Slave environment: memory plus the KNN register file.
    int delay_cfg = 1;
    int zeros_cfg = 0;
    logic [31:0] kb_cfg = '0;
    logic [31:0] mem_ovr [logic [31:0]];
    int wcnt;
    int done_reads;
    logic [31:0] sel_reg;

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[15:0] ^ 16'h5A5A, a[31:16] + a[15:0]};
    endfunction

    function automatic logic [31:0] outword(input int s);
        return 32'hC0DE_0000 ^ (32'(s) * 32'h0101_0011);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready <= 1'b0; m_rdata <= '0; wcnt <= 0; done_reads <= 0; sel_reg <= '0;
        end else begin
            if (start) done_reads <= 0;
            if (m_ready) m_ready <= 1'b0;
            else if (m_valid) begin
                if (wcnt + 1 >= delay_cfg) begin
                    wcnt <= 0;
                    m_ready <= 1'b1;
                    if (m_wstrb == '0) begin
                        if (m_address == kb_cfg + 32'd16) begin
                            m_rdata <= (zeros_cfg < 0 || done_reads < zeros_cfg) ? 32'h0 : 32'h1;
                            done_reads <= done_reads + 1;
                        end else if (m_address == kb_cfg + 32'd20)
                            m_rdata <= outword(int'(sel_reg));
                        else
                            m_rdata <= mem_at(m_address);
                    end else if (m_address == kb_cfg + 32'd12)
                        sel_reg <= m_wdata;
                end else
                    wcnt <= wcnt + 1;
            end else
                wcnt <= 0;
        end
    end

    // Bus monitor.
    typedef struct packed { logic w; logic sok; logic [31:0] addr; logic [31:0] data; } txn_t;
    typedef struct packed { logic [IW-1:0] idx; logic [31:0] data; } res_t;
    txn_t trace_q[$];
    txn_t exp_q[$];
    res_t res_q[$];
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_wtr_cyc = 0, viol = 0, mvalid_cnt = 0;
    logic done_err = 1'b0;
    logic prev_v = 1'b0, prev_r = 1'b0, prev_c = 1'b0;
    logic [AW+DW+DW/8-1:0] prev_bus = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            prev_v <= 1'b0; prev_r <= 1'b0; prev_c <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                trace_q.push_back('{(m_wstrb == '1), (m_wstrb == '1 || m_wstrb == '0), m_address, m_wdata});
                if (m_wstrb == '1 && m_address == kb_cfg + 32'd8) last_wtr_cyc <= cyc;
            end
            if (res_valid) res_q.push_back('{res_idx, res_data});
            if (done) begin done_cnt <= done_cnt + 1; done_err <= error; done_cyc <= cyc; end
            if (m_valid) mvalid_cnt <= mvalid_cnt + 1;
            if (prev_c && m_valid) viol <= viol + 1;
            else if (prev_v && !prev_r && m_valid && {m_address, m_wdata, m_wstrb} != prev_bus) viol <= viol + 1;
            prev_v <= m_valid; prev_r <= m_ready; prev_c <= m_valid && m_ready;
            prev_bus <= {m_address, m_wdata, m_wstrb};
        end
    end

    int tr0, rs0, dn0;

    task automatic build_exp(input logic [31:0] kb, input logic [31:0] tp, input logic [31:0] tb,
                             input int cnt, input int zeros);
        exp_q.delete();
        exp_q.push_back('{1'b1, 1'b1, kb, 32'd1});
        exp_q.push_back('{1'b1, 1'b1, kb, 32'd0});
        exp_q.push_back('{1'b1, 1'b1, kb + 32'd4, tp});
        for (int k = 0; k < cnt; k++) begin
            logic [31:0] a;
            a = tb + 32'(4 * k);
            exp_q.push_back('{1'b0, 1'b1, a, 32'd0});
            exp_q.push_back('{1'b1, 1'b1, kb + 32'd8, mem_at(a)});
        end
        for (int p = 0; p <= zeros; p++) exp_q.push_back('{1'b0, 1'b1, kb + 32'd16, 32'd0});
        for (int s = 0; s < KK; s++) begin
            exp_q.push_back('{1'b1, 1'b1, kb + 32'd12, 32'(s)});
            exp_q.push_back('{1'b0, 1'b1, kb + 32'd20, 32'd0});
        end
    endtask

    function automatic int trace_diff();
        int n;
        n = trace_q.size() - tr0;
        for (int k = 0; k < exp_q.size() && k < n; k++) begin
            txn_t a, e;
            a = trace_q[tr0 + k];
            e = exp_q[k];
            if (a.w !== e.w || a.sok !== 1'b1 || a.addr !== e.addr || (e.w && a.data !== e.data)) return k;
        end
        if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
        return -1;
    endfunction

    function automatic int res_diff();
        for (int s = 0; s < KK; s++) begin
            if (res_q.size() - rs0 <= s) return s;
            if (res_q[rs0 + s].idx !== IW'(s) || res_q[rs0 + s].data !== outword(s)) return s;
        end
        if (res_q.size() - rs0 != KK) return KK;
        return -1;
    endfunction

    task automatic start_job(input logic [31:0] tp, input logic [31:0] tb, input int cnt, input logic [31:0] kb);
        @(negedge clk);
        #1;
        tr0 = trace_q.size(); rs0 = res_q.size(); dn0 = done_cnt;
        test_point = tp; train_base = tb; train_cnt = CW'(cnt); knn_base = kb; kb_cfg = kb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (done_cnt > dn0) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        vectors++;
        if ({busy, done, error, res_valid} !== 4'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b want 0000", {busy, done, error, res_valid});
        end
        vectors++;
        if ({m_address, m_wstrb} !== '0) begin
            miscompares++; $display("FAIL reset_bus: got %h/%h want 0/0", m_address, m_wstrb);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        int d;
        mem_ovr[32'h0000_1000] = 32'h0005_0005;
        mem_ovr[32'h0000_1004] = 32'h0001_0001;
        mem_ovr[32'h0000_1008] = 32'h0003_0003;
        delay_cfg = 1; zeros_cfg = 0;
        build_exp(32'h4000_0000, 32'h0002_0001, 32'h0000_1000, 3, 0);
        start_job(32'h0002_0001, 32'h0000_1000, 3, 32'h4000_0000);
        wait_done(500, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL basic_done_timeout: no done within 500 cycles"); end
        d = trace_diff();
        vectors++;
        if (d !== -1) begin miscompares++; $display("FAIL basic_trace: first bad txn %0d of %0d, want none", d, exp_q.size()); end
        d = res_diff();
        vectors++;
        if (d !== -1) begin miscompares++; $display("FAIL basic_results: first bad result %0d, want none", d); end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (done_cnt - dn0 !== 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - dn0); end
        vectors++;
        if ({done_err, busy} !== 2'b00) begin miscompares++; $display("FAIL basic_err_busy: got %b want 00", {done_err, busy}); end
    endtask

    task automatic test_random();
        bit to;
        int d;
        for (int n = 0; n < 4; n++) begin
            int cnt, zeros;
            logic [31:0] tp, tb, kb;
            cnt = $urandom_range(1, 6); zeros = $urandom_range(0, 3);
            delay_cfg = $urandom_range(1, 3); zeros_cfg = zeros;
            tp = $urandom;
            tb = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
            kb = 32'hA000_0000 | ($urandom & 32'h0FFF_FF00);
            build_exp(kb, tp, tb, cnt, zeros);
            start_job(tp, tb, cnt, kb);
            wait_done(2000, to);
            d = trace_diff();
            vectors++;
            if (to || d !== -1) begin miscompares++; $display("FAIL random_trace[%0d]: timeout=%0d bad txn %0d, want none", n, to, d); end
            d = res_diff();
            vectors++;
            if (d !== -1 || done_err !== 1'b0) begin
                miscompares++; $display("FAIL random_results[%0d]: bad result %0d err %b, want none/0", n, d, done_err);
            end
        end
    endtask

    task automatic test_delay();
        bit to;
        int d, v0;
        v0 = viol;
        delay_cfg = 3; zeros_cfg = 1;
        build_exp(32'hB000_0100, 32'h1234_5678, 32'h2000_0000, 3, 1);
        start_job(32'h1234_5678, 32'h2000_0000, 3, 32'hB000_0100);
        wait_done(2000, to);
        d = trace_diff();
        vectors++;
        if (to || d !== -1) begin miscompares++; $display("FAIL delay_trace: timeout=%0d bad txn %0d, want none", to, d); end
        vectors++;
        if (viol - v0 !== 0) begin miscompares++; $display("FAIL delay_protocol: got %0d violations want 0", viol - v0); end
    endtask

    task automatic test_polls();
        bit to;
        int d, polls;
        delay_cfg = 1; zeros_cfg = 4;
        build_exp(32'hC000_0000, 32'h0000_0003, 32'h3000_0000, 2, 4);
        start_job(32'h0000_0003, 32'h3000_0000, 2, 32'hC000_0000);
        wait_done(1000, to);
        polls = 0;
        for (int k = tr0; k < trace_q.size(); k++) begin
            if (trace_q[k].w && trace_q[k].addr == 32'hC000_000C) break;
            if (!trace_q[k].w && trace_q[k].addr == 32'hC000_0010) polls++;
        end
        vectors++;
        if (polls !== 5) begin miscompares++; $display("FAIL poll_count: got %0d DONE reads want 5", polls); end
        d = trace_diff();
        vectors++;
        if (to || d !== -1) begin miscompares++; $display("FAIL poll_trace: timeout=%0d bad txn %0d, want none", to, d); end
    endtask

    task automatic test_zero_cnt();
        int mv0;
        mv0 = mvalid_cnt;
        start_job(32'hDEAD_BEEF, 32'h0000_4000, 0, 32'hD000_0000);
        #1;
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done_timing: got %b want 1", done); end
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (mvalid_cnt - mv0 !== 0 || res_q.size() - rs0 !== 0) begin
            miscompares++; $display("FAIL zero_no_traffic: got %0d valid cycles %0d results want 0/0", mvalid_cnt - mv0, res_q.size() - rs0);
        end
        vectors++;
        if (done_cnt - dn0 !== 1) begin miscompares++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - dn0); end
    endtask

    task automatic test_wrap();
        bit to;
        int d;
        delay_cfg = 1; zeros_cfg = 0;
        build_exp(32'h5000_0000, 32'h0F0F_F0F0, 32'hFFFF_FFF8, 4, 0);
        start_job(32'h0F0F_F0F0, 32'hFFFF_FFF8, 4, 32'h5000_0000);
        wait_done(1000, to);
        d = trace_diff();
        vectors++;
        if (to || d !== -1) begin miscompares++; $display("FAIL wrap_trace: timeout=%0d bad txn %0d, want none", to, d); end
        vectors++;
        if (trace_q.size() - tr0 < 8 || trace_q[tr0 + 7].addr !== 32'h0000_0000) begin
            miscompares++; $display("FAIL wrap_addr: third training read wrong, want address 00000000");
        end
    endtask

    task automatic test_reset_mid();
        bit to, found;
        int d;
        logic [31:0] tb;
        delay_cfg = 2; zeros_cfg = 0;
        tb = 32'h6000_0040;
        start_job(32'h0101_0202, tb, 4, 32'hE000_0000);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (m_valid && m_wstrb == '0 && m_address == tb) found = 1'b1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL rstmid_reach: RDTR request not seen, want seen"); end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({m_valid, busy, done} !== 3'b000) begin
            miscompares++; $display("FAIL rstmid_drop: got valid/busy/done %b want 000", {m_valid, busy, done});
        end
        @(negedge clk);
        rst = 1'b1;
        delay_cfg = $urandom_range(1, 3); zeros_cfg = 1;
        build_exp(32'hE100_0000, 32'h7777_1111, 32'h6100_0000, 3, 1);
        start_job(32'h7777_1111, 32'h6100_0000, 3, 32'hE100_0000);
        repeat (6) @(negedge clk);
        test_point = 32'hFFFF_FFFF; train_base = 32'h0; train_cnt = 16'd9; knn_base = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, to);
        d = trace_diff();
        vectors++;
        if (to || d !== -1) begin miscompares++; $display("FAIL rstmid_rerun_trace: timeout=%0d bad txn %0d, want none", to, d); end
        d = res_diff();
        vectors++;
        if (d !== -1) begin miscompares++; $display("FAIL rstmid_rerun_results: bad result %0d want none", d); end
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (done_cnt - dn0 !== 1) begin miscompares++; $display("FAIL rstmid_done_count: got %0d want 1", done_cnt - dn0); end
    endtask

    task automatic test_timeout();
`ifdef KNN_TIMEOUT_EN
        bit to;
        int d, dd;
        delay_cfg = 1; zeros_cfg = -1;
        start_job(32'h0000_0001, 32'h7000_0000, 2, 32'hF000_0000);
        wait_done(400, to);
        vectors++;
        if (to || done_err !== 1'b1) begin miscompares++; $display("FAIL timeout_error: timeout=%0d err %b want 0/1", to, done_err); end
        dd = done_cyc - last_wtr_cyc;
        vectors++;
        if (dd < 2 || dd > 18) begin miscompares++; $display("FAIL timeout_latency: got %0d cycles want 2..18", dd); end
        vectors++;
        if (res_q.size() - rs0 !== 0) begin miscompares++; $display("FAIL timeout_no_results: got %0d want 0", res_q.size() - rs0); end
        zeros_cfg = 0;
        build_exp(32'hF100_0000, 32'h0000_0002, 32'h7100_0000, 1, 0);
        start_job(32'h0000_0002, 32'h7100_0000, 1, 32'hF100_0000);
        wait_done(500, to);
        d = trace_diff();
        vectors++;
        if (to || d !== -1 || done_err !== 1'b0) begin
            miscompares++; $display("FAIL timeout_recover: timeout=%0d bad txn %0d err %b want 0/none/0", to, d, done_err);
        end
`else
        delay_cfg = 1; zeros_cfg = -1;
        start_job(32'h0000_0001, 32'h7000_0000, 2, 32'hF000_0000);
        repeat (300) @(negedge clk);
        #1;
        vectors++;
        if ({busy, error} !== 2'b10 || done_cnt - dn0 !== 0) begin
            miscompares++; $display("FAIL stuck_poll_waits: busy/error %b done %0d want 10/0", {busy, error}, done_cnt - dn0);
        end
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL stuck_poll_reset: busy %b want 0", busy); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_delay();
        test_polls();
        test_zero_cnt();
        test_wrap();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
